// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: level-triggered transmitter and centre-sampling receiver.
// Define UART_RX_SYNC_EN to put a two-flop synchroniser in front of the receiver.
module uart_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       uart_wr_i,
    input  logic [7:0] uart_dat_i,
    output logic       uart_busy,
    output logic       uart_tx,
    input  logic       uart_rd_i,
    input  logic       uart_rx,
    output logic [7:0] uart_dat_o,
    output logic       uart_rx_busy,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        tx_state, tx_state_next;
    logic [CW-1:0] tx_cnt, tx_cnt_next;
    logic [2:0]    tx_bit, tx_bit_next;
    logic [7:0]    tx_shift, tx_shift_next;
    logic          tx_next, busy_next;

    state_t        rx_state, rx_state_next;
    logic [CW-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]    rx_bit, rx_bit_next;
    logic [7:0]    rx_shift, rx_shift_next;
    logic [7:0]    dat_next;
    logic          rx_busy_next, done_next;
    logic          rx_line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) rx_sync <= 2'b11;
        else           rx_sync <= {rx_sync[0], uart_rx};
    end

    assign rx_line = rx_sync[1];
`else
    assign rx_line = uart_rx;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            uart_tx   <= 1'b1;
            uart_busy <= 1'b0;
        end else begin
            tx_state  <= tx_state_next;
            tx_cnt    <= tx_cnt_next;
            tx_bit    <= tx_bit_next;
            tx_shift  <= tx_shift_next;
            uart_tx   <= tx_next;
            uart_busy <= busy_next;
        end
    end

    // The line value for the coming bit is registered at each bit boundary, so uart_tx is glitch-free.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_next       = uart_tx;
        busy_next     = uart_busy;
        case (tx_state)
            IDLE: begin
                if (uart_wr_i) begin
                    tx_shift_next = uart_dat_i;
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_next       = 1'b0;
                    busy_next     = 1'b1;
                    tx_state_next = START;
                end
            end
            START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_next       = tx_shift[0];
                    tx_state_next = DATA;
                end else begin
                    tx_cnt_next = tx_cnt + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit == 3'd7) begin
                        tx_next       = 1'b1;
                        tx_state_next = STOP;
                    end else begin
                        tx_bit_next   = tx_bit + 3'd1;
                        tx_shift_next = tx_shift >> 1;
                        tx_next       = tx_shift[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_next       = 1'b1;
                    busy_next     = 1'b0;
                    tx_state_next = IDLE;
                end else begin
                    tx_cnt_next = tx_cnt + 1'b1;
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            uart_dat_o   <= '0;
            uart_rx_busy <= 1'b0;
            done         <= 1'b0;
        end else begin
            rx_state     <= rx_state_next;
            rx_cnt       <= rx_cnt_next;
            rx_bit       <= rx_bit_next;
            rx_shift     <= rx_shift_next;
            uart_dat_o   <= dat_next;
            uart_rx_busy <= rx_busy_next;
            done         <= done_next;
        end
    end

    // START only waits half a bit, which puts every later sample at a bit centre.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        dat_next      = uart_dat_o;
        rx_busy_next  = uart_rx_busy;
        done_next     = 1'b0;
        case (rx_state)
            IDLE: begin
                if (uart_rd_i && !rx_line) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_busy_next  = 1'b1;
                    rx_state_next = START;
                end
            end
            START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_line) begin
                        rx_busy_next  = 1'b0;
                        rx_state_next = IDLE;
                    end else begin
                        rx_state_next = DATA;
                    end
                end else begin
                    rx_cnt_next = rx_cnt + 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_line, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_next = STOP;
                    else                rx_bit_next   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_next = rx_cnt + 1'b1;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_busy_next  = 1'b0;
                    rx_state_next = IDLE;
                    if (rx_line) begin
                        dat_next  = rx_shift;
                        done_next = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt + 1'b1;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: frame-level model of the 8N1 line, randomized bytes.
module tb_uart_core;

    localparam int CPB  = 434;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int DONE_AT = HALF + 9 * CPB + SYNC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] dat_in = 8'h00;
    logic       busy;
    logic       tx;
    logic       rd = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dat_out;
    logic       rx_busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .sys_clk_i   (clk),
        .sys_rst_i   (rst),
        .uart_wr_i   (wr),
        .uart_dat_i  (dat_in),
        .uart_busy   (busy),
        .uart_tx     (tx),
        .uart_rd_i   (rd),
        .uart_rx     (rx),
        .uart_dat_o  (dat_out),
        .uart_rx_busy(rx_busy),
        .done        (done)
    );

    // A frame on the wire, index 0 first: start bit, data LSB first, stop bit.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    task automatic watch_tx(input logic [7:0] data, input int hold, input int pulse_at,
                            output logic [9:0] first, output logic [9:0] last,
                            output int busy_len, output logic tx_after);
        first = '0; last = '0; busy_len = 0; tx_after = 1'b0;
        dat_in = data;
        wr = 1'b1;
        for (int k = 0; k < 10 * CPB + 5; k++) begin
            @(negedge clk);
            if (k == 0) dat_in = ~data;
            wr = (k + 1 < hold) || (k + 1 == pulse_at);
            if (k + 1 == pulse_at) dat_in = data ^ 8'hA5;
            if (busy) busy_len++;
            if (k < 10 * CPB && k % CPB == 0) first[k / CPB] = tx;
            if (k < 10 * CPB && k % CPB == CPB - 1) last[k / CPB] = tx;
            if (k == 10 * CPB) tx_after = tx;
        end
        wr = 1'b0;
    endtask

    task automatic drive_rx(input logic [9:0] bits, output int done_at, output int done_cnt,
                            output logic [7:0] done_data, output int busy_cnt);
        done_at = -1; done_cnt = 0; done_data = '0; busy_cnt = 0;
        rx = bits[0];
        for (int c = 0; c < 11 * CPB; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = c;
                    done_data = dat_out;
                end
            end
            if (rx_busy) busy_cnt++;
            rx = (c + 1 < 10 * CPB) ? bits[(c + 1) / CPB] : 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_busy: got %b want 0", rx_busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (dat_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_dat: got %h want 00", dat_out); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_tx_single();
        logic [9:0] first, last;
        int         busy_len;
        logic       tx_after;
        watch_tx(8'h1B, 10, -1, first, last, busy_len, tx_after);
        checks++; if (first !== frame_of(8'h1B)) begin errors++; $display("[TB] FAIL tx_single_bit_start: got %b want %b", first, frame_of(8'h1B)); end
        checks++; if (last !== frame_of(8'h1B)) begin errors++; $display("[TB] FAIL tx_single_bit_end: got %b want %b", last, frame_of(8'h1B)); end
        checks++; if (busy_len !== 10 * CPB) begin errors++; $display("[TB] FAIL tx_single_busy_len: got %0d want %0d", busy_len, 10 * CPB); end
        checks++; if (tx_after !== 1'b1) begin errors++; $display("[TB] FAIL tx_single_idle_line: got %b want 1", tx_after); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] first, last;
        int         busy_len;
        logic       tx_after;
        repeat (5) @(negedge clk);
        watch_tx(8'h1E, 1, 1000, first, last, busy_len, tx_after);
        checks++; if (first !== frame_of(8'h1E)) begin errors++; $display("[TB] FAIL b2b_bit_start: got %b want %b", first, frame_of(8'h1E)); end
        checks++; if (last !== frame_of(8'h1E)) begin errors++; $display("[TB] FAIL b2b_bit_end: got %b want %b", last, frame_of(8'h1E)); end
        checks++; if (busy_len !== 10 * CPB) begin errors++; $display("[TB] FAIL b2b_busy_len: got %0d want %0d", busy_len, 10 * CPB); end
        checks++; if (tx_after !== 1'b1) begin errors++; $display("[TB] FAIL b2b_idle_line: got %b want 1", tx_after); end
    endtask

    task automatic test_rx_good();
        int         done_at, done_cnt, busy_cnt;
        logic [7:0] done_data;
        rd = 1'b1;
        repeat (5) @(negedge clk);
        drive_rx(10'b1011101010, done_at, done_cnt, done_data, busy_cnt);
        checks++; if (done_at !== DONE_AT) begin errors++; $display("[TB] FAIL rx_good_latency: got %0d want %0d", done_at, DONE_AT); end
        checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL rx_good_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_data !== 8'h75) begin errors++; $display("[TB] FAIL rx_good_data: got %h want 75", done_data); end
        checks++; if (busy_cnt !== HALF + 9 * CPB) begin errors++; $display("[TB] FAIL rx_good_busy_len: got %0d want %0d", busy_cnt, HALF + 9 * CPB); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL rx_good_busy_after: got %b want 0", rx_busy); end
        checks++; if (dat_out !== 8'h75) begin errors++; $display("[TB] FAIL rx_good_hold: got %h want 75", dat_out); end
    endtask

    task automatic test_rx_glitch();
        int done_cnt = 0;
        int busy_cnt = 0;
        rx = 1'b0;
        for (int c = 0; c < CPB + 100; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (rx_busy) busy_cnt++;
            if (c + 1 == 100) rx = 1'b1;
        end
        checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL glitch_done: got %0d want 0", done_cnt); end
        checks++; if (busy_cnt !== HALF) begin errors++; $display("[TB] FAIL glitch_busy_len: got %0d want %0d", busy_cnt, HALF); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_idle: got %b want 0", rx_busy); end
        checks++; if (dat_out !== 8'h75) begin errors++; $display("[TB] FAIL glitch_hold: got %h want 75", dat_out); end
    endtask

    task automatic test_rx_framing();
        int         done_at, done_cnt, busy_cnt;
        logic [7:0] done_data;
        drive_rx({1'b0, 8'hC3, 1'b0}, done_at, done_cnt, done_data, busy_cnt);
        checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL framing_done: got %0d want 0", done_cnt); end
        checks++; if (dat_out !== 8'h75) begin errors++; $display("[TB] FAIL framing_hold: got %h want 75", dat_out); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL framing_idle: got %b want 0", rx_busy); end
    endtask

    task automatic test_rx_disabled();
        int         done_at, done_cnt, busy_cnt;
        logic [7:0] done_data;
        rd = 1'b0;
        drive_rx(frame_of(8'h3C), done_at, done_cnt, done_data, busy_cnt);
        checks++; if (done_cnt !== 0) begin errors++; $display("[TB] FAIL disabled_done: got %0d want 0", done_cnt); end
        checks++; if (busy_cnt !== 0) begin errors++; $display("[TB] FAIL disabled_busy: got %0d want 0", busy_cnt); end
        checks++; if (dat_out !== 8'h75) begin errors++; $display("[TB] FAIL disabled_hold: got %h want 75", dat_out); end
        rd = 1'b1;
    endtask

    task automatic test_full_duplex();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] tbyte = 8'($urandom);
            logic [7:0] rbyte = 8'($urandom_range(1, 255));
            logic [9:0] rframe = frame_of(rbyte);
            logic [9:0] seen = '0;
            int         done_at = -1;
            int         done_cnt = 0;
            logic [7:0] done_data = '0;
            rd = 1'b1;
            wr = 1'b1;
            dat_in = tbyte;
            rx = rframe[0];
            for (int c = 0; c < 11 * CPB; c++) begin
                @(negedge clk);
                wr = 1'b0;
                dat_in = 8'($urandom);
                if (c < 10 * CPB && c % CPB == HALF) seen[c / CPB] = tx;
                if (done) begin
                    done_cnt++;
                    if (done_at < 0) begin
                        done_at = c;
                        done_data = dat_out;
                    end
                end
                rx = (c + 1 < 10 * CPB) ? rframe[(c + 1) / CPB] : 1'b1;
            end
            checks++; if (seen !== frame_of(tbyte)) begin errors++; $display("[TB] FAIL duplex_tx_bits[%0d]: got %b want %b", it, seen, frame_of(tbyte)); end
            checks++; if (done_cnt !== 1) begin errors++; $display("[TB] FAIL duplex_done_count[%0d]: got %0d want 1", it, done_cnt); end
            checks++; if (done_at !== DONE_AT) begin errors++; $display("[TB] FAIL duplex_latency[%0d]: got %0d want %0d", it, done_at, DONE_AT); end
            checks++; if (done_data !== rbyte) begin errors++; $display("[TB] FAIL duplex_rx_data[%0d]: got %h want %h", it, done_data, rbyte); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rbyte = 8'($urandom);
        logic [9:0] rframe = frame_of(rbyte);
        wr = 1'b1;
        dat_in = 8'($urandom);
        rx = rframe[0];
        for (int c = 0; c < 4 * CPB + HALF; c++) begin
            @(negedge clk);
            wr = 1'b0;
            rx = rframe[(c + 1) / CPB];
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_tx_busy_before: got %b want 1", busy); end
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_rx_busy_before: got %b want 1", rx_busy); end
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("[TB] FAIL mid_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b want 0", busy); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rx_busy: got %b want 0", rx_busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL mid_done: got %b want 0", done); end
        checks++; if (dat_out !== 8'h00) begin errors++; $display("[TB] FAIL mid_dat: got %h want 00", dat_out); end
        rst = 1'b0;
        repeat (CPB) @(negedge clk);
        checks++; if (busy !== 1'b0 || rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_stays_idle: got busy=%b rx_busy=%b want 0 0", busy, rx_busy); end
    endtask

    initial begin
        $display("[TB] uart_core bench, CLKS_PER_BIT=%0d", CPB);
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_good();
        test_rx_glitch();
        test_rx_framing();
        test_rx_disabled();
        test_full_duplex();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule
